// File: rtl/pixel_writer.sv
// pixel_writer: read-modify-write of single pixels in a 1bpp SRAM frame buffer.
// Layout: H_PIXELS/8 words per line, 8 pixels per word in bits [7:0].
// Optional full-screen clear sweep: define PIXEL_WRITER_CLEAR_EN.
module pixel_writer #(
    parameter int unsigned H_PIXELS     = 640,
    parameter int unsigned V_PIXELS     = 480,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pen_valid,
    input  logic [9:0]  pen_x,
    input  logic [8:0]  pen_y,
    input  logic        pen_colour,
`ifdef PIXEL_WRITER_CLEAR_EN
    input  logic        clear,
`endif
    output logic        busy,
    output logic        done,
    input  logic        ready,
    output logic [17:0] address,
    input  logic [15:0] data_read,
    output logic [15:0] data_write,
    output logic        read,
    output logic        write
);

    localparam int unsigned ADDR_W         = 18;
    localparam int unsigned WORDS_PER_LINE = H_PIXELS / 8;
    localparam int unsigned LAST_WORD      = V_PIXELS * WORDS_PER_LINE - 1;
    localparam int unsigned LAT_W          = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        MODIFY,
        WR_REQ
`ifdef PIXEL_WRITER_CLEAR_EN
        , CLEAR
`endif
    } state_t;

    state_t              state;
    logic [9:0]          x_q;
    logic [8:0]          y_q;
    logic                colour_q;
    logic                rd_armed;
    logic [LAT_W-1:0]    lat_cnt;
    logic [7:0]          old_byte;
`ifdef PIXEL_WRITER_CLEAR_EN
    logic [ADDR_W-1:0]   clr_addr;
`endif

    logic                in_range_c;
    logic [ADDR_W-1:0]   pix_addr_c;
    logic [7:0]          new_byte_c;
    logic                unused_data_hi;

    // Upper half of the SRAM word carries no pixels.
    assign unused_data_hi = ^data_read[15:8];

    // Request bounds check on the live pen inputs.
    assign in_range_c = (32'(pen_x) < H_PIXELS) && (32'(pen_y) < V_PIXELS);

    // Word address of the latched pixel.
    assign pix_addr_c = ADDR_W'(y_q) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(x_q[9:3]);

    // Captured byte with the latched pixel forced to the requested colour.
    always_comb begin
        new_byte_c              = old_byte;
        new_byte_c[x_q[2:0]]    = colour_q;
    end

    // Control FSM with registered SRAM strobes and status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            data_write <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= 1'b0;
            rd_armed   <= 1'b0;
            lat_cnt    <= '0;
            old_byte   <= '0;
`ifdef PIXEL_WRITER_CLEAR_EN
            clr_addr   <= '0;
`endif
        end else begin
            read  <= 1'b0;
            write <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
`ifdef PIXEL_WRITER_CLEAR_EN
                    if (clear && !busy) begin
                        busy     <= 1'b1;
                        clr_addr <= '0;
                        state    <= CLEAR;
                    end else
`endif
                    if (pen_valid && !busy) begin
                        x_q      <= pen_x;
                        y_q      <= pen_y;
                        colour_q <= pen_colour;
                        if (in_range_c) begin
                            busy     <= 1'b1;
                            rd_armed <= 1'b0;
                            state    <= RD_REQ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    if (ready) begin
                        if (!rd_armed) begin
                            address  <= pix_addr_c;
                            rd_armed <= 1'b1;
                        end else begin
                            read     <= 1'b1;
                            rd_armed <= 1'b0;
                            lat_cnt  <= '0;
                            state    <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
                        old_byte <= data_read[7:0];
                        state    <= MODIFY;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                MODIFY: begin
                    if (new_byte_c == old_byte) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (ready) begin
                        data_write <= {8'h00, new_byte_c};
                        write      <= 1'b1;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end
                end
`ifdef PIXEL_WRITER_CLEAR_EN
                CLEAR: begin
                    if (ready) begin
                        address    <= clr_addr;
                        data_write <= '0;
                        write      <= 1'b1;
                        if (clr_addr == ADDR_W'(LAST_WORD)) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            clr_addr <= clr_addr + ADDR_W'(1);
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: SRAM model plus a pixel-level reference.
module tb_pixel_writer;

    localparam int unsigned H     = 640;
    localparam int unsigned V     = 480;
    localparam int unsigned RL    = 2;
    localparam int unsigned WORDS = H * V / 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pen_valid = 1'b0;
    logic [9:0]  pen_x = '0;
    logic [8:0]  pen_y = '0;
    logic        pen_colour = 1'b0;
    logic        clear = 1'b0;
    logic        busy, done, read, write;
    logic        ready = 1'b1;
    logic [17:0] address;
    logic [15:0] data_read = '0;
    logic [15:0] data_write;

    pixel_writer #(.H_PIXELS(H), .V_PIXELS(V), .READ_LATENCY(RL)) dut (
        .clk        (clk),
        .reset      (reset),
        .pen_valid  (pen_valid),
        .pen_x      (pen_x),
        .pen_y      (pen_y),
        .pen_colour (pen_colour),
`ifdef PIXEL_WRITER_CLEAR_EN
        .clear      (clear),
`endif
        .busy       (busy),
        .done       (done),
        .ready      (ready),
        .address    (address),
        .data_read  (data_read),
        .data_write (data_write),
        .read       (read),
        .write      (write)
    );

    always #5 clk = ~clk;

    logic [15:0] mem    [WORDS];
    logic [15:0] refmem [WORDS];
    logic        ready_q = 1'b1;

    // SRAM: write on strobe; read data valid RL edges after the read strobe edge.
    always @(posedge clk) begin
        ready_q <= ready;
        if (write && address < 18'(WORDS)) mem[address] <= data_write;
        data_read <= (read && address < 18'(WORDS)) ? mem[address] : 16'($urandom);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-operation observations
    int          rd_cnt, wr_cnt, done_cnt, rd_rel, wr_rel, done_rel;
    logic [17:0] rd_addr, wr_addr;
    logic [15:0] wr_data;
    logic        busy_seen, busy_at_done, busy_after;
    // Whole-run protocol violation counters
    int          overlap_cnt = 0, noready_cnt = 0, addr_moved = 0;

    task automatic clear_stats();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
        rd_rel = -1; wr_rel = -1; done_rel = -1;
        rd_addr = 'x; wr_addr = 'x; wr_data = 'x;
        busy_seen = 1'b0; busy_at_done = 1'bx; busy_after = 1'bx;
    endtask

    task automatic sample(input int rel);
        if (read && write) overlap_cnt++;
        if (write && !ready_q) noready_cnt++;
        if (busy) busy_seen = 1'b1;
        if (read) begin rd_cnt++; rd_addr = address; rd_rel = rel; end
        if (rd_cnt > 0 && wr_cnt == 0 && address !== rd_addr) addr_moved++;
        if (write) begin wr_cnt++; wr_addr = address; wr_data = data_write; wr_rel = rel; end
        if (done) begin done_cnt++; done_rel = rel; busy_at_done = busy; end
        if (done_cnt > 0 && rel == done_rel + 1) busy_after = busy;
    endtask

    // Pixel-level reference: which word, and what it must hold afterwards.
    task automatic model(input int x, input int y, input int c,
                         output bit in_range, output bit changed,
                         output int addr, output logic [15:0] new_word);
        logic [7:0] old_b, mask, new_b;
        in_range = (x < int'(H)) && (y < int'(V));
        addr = 0; changed = 0; new_word = '0;
        if (in_range) begin
            addr  = y * int'(H / 8) + x / 8;
            old_b = refmem[addr][7:0];
            mask  = 8'h01 << (x % 8);
            new_b = (c != 0) ? (old_b | mask) : (old_b & ~mask);
            changed  = (new_b != old_b);
            new_word = {8'h00, new_b};
        end
    endtask

    task automatic run_op(input int x, input int y, input int c,
                          input int srd, input int swr, input bit rnd, input string tag);
        bit ir, ch;
        int addr, rel;
        logic [15:0] nw;
        model(x, y, c, ir, ch, addr, nw);
        clear_stats();
        @(negedge clk);
        pen_x = 10'(x); pen_y = 9'(y); pen_colour = 1'(c); pen_valid = 1'b1;
        ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(negedge clk);
        pen_valid = 1'b0;
        rel = 0;
        while (1) begin
            sample(rel);
            if (done_cnt > 0 && rel >= done_rel + 1) break;
            if (rel >= 300) break;
            if (rnd) ready = ($urandom_range(0, 3) != 0);
            else ready = !((rel < srd) || (swr > 0 && rel >= 5 + srd && rel < 5 + srd + swr));
            @(negedge clk);
            rel++;
        end
        ready = 1'b1;
        check({tag, ".done_cnt"}, done_cnt, 1);
        if (!ir) begin
            check({tag, ".oor_reads"}, rd_cnt, 0);
            check({tag, ".oor_writes"}, wr_cnt, 0);
            check({tag, ".oor_busy"}, 32'(busy_seen), 0);
            check({tag, ".oor_done_rel"}, done_rel, 0);
        end else begin
            check({tag, ".reads"}, rd_cnt, 1);
            check({tag, ".rd_addr"}, 32'(rd_addr), addr);
            check({tag, ".writes"}, wr_cnt, ch ? 1 : 0);
            if (ch) begin
                check({tag, ".wr_addr"}, 32'(wr_addr), addr);
                check({tag, ".wr_data"}, 32'(wr_data), 32'(nw));
                refmem[addr] = nw;
            end
            check({tag, ".busy_at_done"}, 32'(busy_at_done), 1);
            check({tag, ".busy_after"}, 32'(busy_after), 0);
            if (!rnd) begin
                check({tag, ".rd_rel"}, rd_rel, 2 + srd);
                if (ch) begin
                    check({tag, ".wr_rel"}, wr_rel, 4 + RL + srd + swr);
                    check({tag, ".done_rel"}, done_rel, 4 + RL + srd + swr);
                end else begin
                    check({tag, ".skip_done_rel"}, done_rel, 3 + RL + srd);
                end
            end
        end
    endtask

    initial begin
        int x, y, r, a, bad;
        for (int i = 0; i < int'(WORDS); i++) begin
            mem[i]    = 16'($urandom);
            refmem[i] = mem[i];
        end
        mem[813] = 16'h0000; refmem[813] = 16'h0000;
        mem[0]   = 16'h0000; refmem[0]   = 16'h0000;
        mem[243] = 16'h0000; refmem[243] = 16'h0000;

        repeat (3) @(negedge clk);
        check("reset.ctl", 32'({busy, done, read, write}), 0);
        check("reset.addr", 32'(address), 0);
        check("reset.wdata", 32'(data_write), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_op(105, 10, 1, 0, 0, 0, "set");
        run_op(0, 0, 0, 0, 0, 0, "redundant");
        run_op(640, 0, 1, 0, 0, 0, "oor_x");
        run_op(0, 480, 1, 0, 0, 0, "oor_y");
        run_op(639, 479, 1, 0, 0, 0, "corner");
        run_op(106, 10, 1, 5, 5, 0, "stall");

        // Reset during RD_WAIT abandons the op with no SRAM write.
        clear_stats();
        @(negedge clk);
        pen_x = 10'd24; pen_y = 9'd3; pen_colour = 1'b1; pen_valid = 1'b1;
        @(negedge clk);
        pen_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst.ctl", 32'({busy, done, read, write}), 0);
        check("midrst.addr", 32'(address), 0);
        check("midrst.wdata", 32'(data_write), 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sample(i);
        end
        check("midrst.writes", wr_cnt, 0);
        check("midrst.mem", 32'(mem[243]), 0);
        run_op(24, 3, 1, 0, 0, 0, "after_rst");

        // Random pixel traffic, first with steady ready (timing checked), then random ready.
        for (int n = 0; n < 90; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                x = $urandom_range(640, 1023); y = $urandom_range(0, 511);
            end else if (r == 1) begin
                x = $urandom_range(0, 639); y = $urandom_range(480, 511);
            end else if (r < 6) begin
                x = $urandom_range(0, 23); y = $urandom_range(0, 1);
            end else begin
                x = $urandom_range(0, 639); y = $urandom_range(0, 479);
            end
            run_op(x, y, $urandom_range(0, 1), 0, 0, (n >= 30), "rand");
        end

`ifdef PIXEL_WRITER_CLEAR_EN
        begin
            int wr, rd, dn, bad_seq, busy_low, cyc;
            logic [17:0] exp_a, done_addr;
            logic done_w;
            wr = 0; rd = 0; dn = 0; bad_seq = 0; busy_low = 0; cyc = 0;
            exp_a = '0; done_addr = '0; done_w = 1'b0;
            @(negedge clk);
            clear = 1'b1; pen_valid = 1'b1; pen_x = 10'd5; pen_y = 9'd5; pen_colour = 1'b1;
            @(negedge clk);
            clear = 1'b0; pen_valid = 1'b0;
            while (cyc < 60000) begin
                if (read) rd++;
                if (read && write) overlap_cnt++;
                if (write && !ready_q) noready_cnt++;
                if (dn == 0 && !busy) busy_low++;
                if (write) begin
                    if (address !== exp_a || data_write !== 16'h0000) bad_seq++;
                    exp_a = exp_a + 18'd1;
                    wr++;
                end
                if (done) begin dn++; done_addr = address; done_w = write; end
                if (dn > 0 && !done) break;
                ready = ($urandom_range(0, 7) != 0);
                @(negedge clk);
                cyc++;
            end
            ready = 1'b1;
            check("clear.writes", wr, WORDS);
            check("clear.seq", bad_seq, 0);
            check("clear.reads", rd, 0);
            check("clear.done_cnt", dn, 1);
            check("clear.done_addr", 32'(done_addr), WORDS - 1);
            check("clear.done_with_write", 32'(done_w), 1);
            check("clear.busy", busy_low, 0);
            for (int i = 0; i < int'(WORDS); i++) refmem[i] = 16'h0000;
            repeat (5) @(negedge clk);
            check("clear.no_pen_read", 32'(read), 0);
            run_op(7, 0, 1, 0, 0, 0, "post_clear");
        end
`endif

        check("proto.rd_wr_overlap", overlap_cnt, 0);
        check("proto.write_without_ready", noready_cnt, 0);
        check("proto.addr_held", addr_moved, 0);
        bad = 0;
        for (int i = 0; i < int'(WORDS); i++) if (mem[i] !== refmem[i]) bad++;
        check("mem.final", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_writer.md
# pixel_writer

Draws into the 1-bit-per-pixel SRAM frame buffer that the display path reads back for VGA output. It accepts single-pixel set/erase requests (x, y, colour) from the pen-tracking logic and performs a read-modify-write of the 16-bit SRAM word that holds that pixel. It talks to the SRAM controller through the same ready/address/read interface the display reader uses, plus a write strobe. The layout matches the reader: 80 words per line, 8 pixels per word in the lower byte.

## Interface
- H_PIXELS, 640, visible pixels per line; must be a multiple of 8.
- V_PIXELS, 480, visible lines.
- READ_LATENCY, 2, clock cycles from the `read` pulse until `data_read` is valid.

- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pen_valid  in  1  pixel request present.
- pen_x  in  10  pixel column.
- pen_y  in  9  pixel line.
- pen_colour  in  1  1 = set pixel, 0 = erase pixel.
- clear  in  1  start a full-screen clear; present only with PIXEL_WRITER_CLEAR_EN.
- busy  out  1  high while an operation is in progress; requests are refused while it is high.
- done  out  1  one-cycle pulse when an operation finishes.
- ready  in  1  SRAM controller can accept a command this cycle.
- address  out  18  SRAM word address.
- data_read  in  16  SRAM read data; only [7:0] is used.
- data_write  out  16  SRAM write data; [15:8] is always 0.
- read  out  1  one-cycle read strobe.
- write  out  1  one-cycle write strobe.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, MODIFY, WR_REQ, CLEAR (CLEAR exists only with the macro).
- **IDLE:** a request is accepted when `pen_valid` is high and `busy` is low.
  - On acceptance, latch x, y and colour, then go to RD_REQ.
  - If x ≥ H_PIXELS or y ≥ V_PIXELS, the request is dropped: no SRAM access, `done` pulses on the next cycle.
- **Address:** y*(H_PIXELS/8) + x[9:3], computed 18 bits wide. The maximum is 38399.
- **Pixel bit:** the pixel lives at bit x[2:0] of the lower byte.
- **RD_REQ:** wait for `ready`. When it is high, drive `address`, pulse `read` on the next cycle, then go to RD_WAIT.
- **RD_WAIT:** count READ_LATENCY cycles from the `read` pulse, capture `data_read[7:0]`, then go to MODIFY.
- **MODIFY:** set or clear the pixel bit in the captured byte.
  - If the new byte equals the old byte, skip the write: pulse `done` and return to IDLE.
  - Otherwise go to WR_REQ.
- **WR_REQ:** wait for `ready`. Then drive `address` with `data_write = {8'h00, new_byte}`, pulse `write` for one cycle, pulse `done` in the same cycle, and return to IDLE.
- `busy` is high from the cycle after acceptance until the cycle after `done`.
- **Reset values:** `busy`, `done`, `read`, `write` = 0; `address`, `data_write` = 0; state = IDLE.
- **Reset mid-operation:** the operation is abandoned. SRAM is either untouched, or the write has already completed in full; no partial word is ever written.
- **Ready dropping:** `ready` low in RD_REQ or WR_REQ stalls the block indefinitely. Strobes are never issued without `ready`.

## Timing
- With `ready` held high:
  - acceptance at edge 0 → `read` high in cycle 2;
  - data captured at cycle 2+READ_LATENCY;
  - `write` and `done` high at cycle 4+READ_LATENCY (cycle 6 with default parameters);
  - `busy` low at cycle 5+READ_LATENCY.
- When the write is skipped, `done` is high at cycle 3+READ_LATENCY.
- `read` and `write` are never high in the same cycle. Each is high for exactly one cycle per access.
- `address` holds its value from the cycle the command is issued until the next command.

## Configuration
- **PIXEL_WRITER_CLEAR_EN defined:**
  - The `clear` input and the CLEAR state exist.
  - `clear` high in IDLE starts a sweep; it wins over a simultaneous `pen_valid`, and that pen request is not accepted.
  - The sweep writes 16'h0000 to addresses 0 through V_PIXELS*H_PIXELS/8−1 in ascending order, one `write` per `ready`. There are no reads.
  - `busy` stays high throughout the sweep. `done` pulses with the final write.
- **PIXEL_WRITER_CLEAR_EN undefined:** the `clear` port is absent and the block performs pixel operations only.

## Test plan
- Set pixel: SRAM word 813 = 16'h0000; request x=105, y=10, colour=1 with `ready` high → `read` at address 813; `write` at address 813 with data 16'h0002; `done` in cycle 6.
- Redundant erase: word 0 = 16'h0000; request x=0, y=0, colour=0 → one `read`, no `write`; `done` in cycle 5.
- Out of range: request x=640, y=0 → no `read` or `write`; `done` one cycle later; `busy` never high.
- Ready stall: `ready` held low for 5 cycles while in RD_REQ, and again in WR_REQ → strobes are delayed by exactly 5 cycles each; address and data are unchanged.
- Reset mid-op: assert `reset` low during RD_WAIT → all outputs 0 immediately; SRAM is unwritten; the next request is handled normally.
- Clear (macro defined): `clear` and `pen_valid` high together → 38400 writes of 16'h0000 to addresses 0..38399; the pen request is not accepted; `done` coincides with the write to address 38399.
